// File: rtl/config_matrix_mult_engine.sv
// Runtime-configurable C = A x B engine with signed/unsigned operands, transposed-B addressing,
// optional output saturation and a valid/ready result stream emitted in row-major order.
module config_matrix_mult_engine #(
    parameter int MAX_M      = 4,
    parameter int MAX_N      = 4,
    parameter int MAX_P      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int SATURATE   = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [$clog2(MAX_M+1)-1:0]        m_cfg,
    input  logic [$clog2(MAX_N+1)-1:0]        n_cfg,
    input  logic [$clog2(MAX_P+1)-1:0]        p_cfg,
    input  logic                              signed_md,
    input  logic                              trans_b,
    input  logic [DATA_WIDTH-1:0]             a_in,
    input  logic [$clog2(MAX_M*MAX_N)-1:0]    a_addr,
    input  logic                              a_wen,
    input  logic [DATA_WIDTH-1:0]             b_in,
    input  logic [$clog2(MAX_N*MAX_P)-1:0]    b_addr,
    input  logic                              b_wen,
    output logic [OUT_WIDTH-1:0]              c_out,
    output logic [$clog2(MAX_M)-1:0]          c_row,
    output logic [$clog2(MAX_P)-1:0]          c_col,
    output logic                              c_valid,
    input  logic                              c_ready,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);

    localparam int MW    = $clog2(MAX_M+1);
    localparam int NW    = $clog2(MAX_N+1);
    localparam int PW    = $clog2(MAX_P+1);
    localparam int RW    = $clog2(MAX_M);
    localparam int CW    = $clog2(MAX_P);
    localparam int KW    = $clog2(MAX_N);
    localparam int AAW   = $clog2(MAX_M*MAX_N);
    localparam int BAW   = $clog2(MAX_N*MAX_P);
    localparam int ACC_W = 2*DATA_WIDTH + $clog2(MAX_N) + 1;
    localparam int XW    = ACC_W + OUT_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_WIDTH-1:0] r_a_bank [MAX_M*MAX_N];
    logic [DATA_WIDTH-1:0] r_b_bank [MAX_N*MAX_P];

    logic [MW-1:0]    r_m;
    logic [NW-1:0]    r_n;
    logic [PW-1:0]    r_p;
    logic             r_sgn;
    logic             r_trans;
    logic [RW-1:0]    r_r;
    logic [CW-1:0]    r_c;
    logic [KW-1:0]    r_k;
    logic [ACC_W-1:0] r_acc;

    logic             w_legal;
    logic             w_k_last;
    logic             w_c_last;
    logic             w_last_elem;
    logic             w_hs;
    logic [AAW-1:0]   w_a_idx;
    logic [BAW-1:0]   w_b_idx;
    logic [DATA_WIDTH-1:0] w_a_val;
    logic [DATA_WIDTH-1:0] w_b_val;
    logic [ACC_W-1:0] w_a_ext;
    logic [ACC_W-1:0] w_b_ext;
    logic [ACC_W-1:0] w_prod;
    logic [ACC_W-1:0] w_acc_sum;

    // Clamp (or truncate) the accumulator to the output width, honouring the operand signedness.
    function automatic logic [OUT_WIDTH-1:0] f_result(input logic [ACC_W-1:0] acc, input logic sgn);
        logic signed [XW-1:0] v_s;
        logic signed [XW-1:0] hi_s;
        logic signed [XW-1:0] lo_s;
        v_s  = {{(XW-ACC_W){sgn & acc[ACC_W-1]}}, acc};
        hi_s = sgn ? (XW'(1'b1) << (OUT_WIDTH-1)) - XW'(1'b1) : (XW'(1'b1) << OUT_WIDTH) - XW'(1'b1);
        lo_s = sgn ? -(XW'(1'b1) << (OUT_WIDTH-1)) : '0;
        if (SATURATE == 0) begin
            f_result = v_s[OUT_WIDTH-1:0];
        end else if (v_s > hi_s) begin
            f_result = hi_s[OUT_WIDTH-1:0];
        end else if (v_s < lo_s) begin
            f_result = lo_s[OUT_WIDTH-1:0];
        end else begin
            f_result = v_s[OUT_WIDTH-1:0];
        end
    endfunction

    assign w_legal = (m_cfg != '0) && (n_cfg != '0) && (p_cfg != '0) &&
                     (m_cfg <= MW'(MAX_M)) && (n_cfg <= NW'(MAX_N)) && (p_cfg <= PW'(MAX_P));

    assign w_k_last    = (r_k == KW'(r_n - NW'(1'b1)));
    assign w_c_last    = (r_c == CW'(r_p - PW'(1'b1)));
    assign w_last_elem = w_c_last && (r_r == RW'(r_m - MW'(1'b1)));
    assign w_hs        = c_valid && c_ready;

    // Operand addresses use the runtime stride, so a smaller matrix packs densely from address 0.
    assign w_a_idx = AAW'(int'(r_r) * int'(r_n) + int'(r_k));
    assign w_b_idx = r_trans ? BAW'(int'(r_c) * int'(r_n) + int'(r_k))
                             : BAW'(int'(r_k) * int'(r_p) + int'(r_c));

    assign w_a_val   = r_a_bank[w_a_idx];
    assign w_b_val   = r_b_bank[w_b_idx];
    assign w_a_ext   = {{(ACC_W-DATA_WIDTH){r_sgn & w_a_val[DATA_WIDTH-1]}}, w_a_val};
    assign w_b_ext   = {{(ACC_W-DATA_WIDTH){r_sgn & w_b_val[DATA_WIDTH-1]}}, w_b_val};
    assign w_prod    = w_a_ext * w_b_ext;
    assign w_acc_sum = r_acc + w_prod;

    // Operand banks: host writes land only while idle; contents survive reset.
    always_ff @(posedge clk) begin
        if (a_wen && (r_state == S_IDLE)) begin
            r_a_bank[a_addr] <= a_in;
        end
        if (b_wen && (r_state == S_IDLE)) begin
            r_b_bank[b_addr] <= b_in;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && w_legal) begin
                    w_state_nxt = S_MAC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MAC: begin
                if (w_k_last) begin
                    w_state_nxt = S_OUT;
                end else begin
                    w_state_nxt = S_MAC;
                end
            end
            S_OUT: begin
                if (w_hs && w_last_elem) begin
                    w_state_nxt = S_DONE;
                end else if (w_hs) begin
                    w_state_nxt = S_MAC;
                end else begin
                    w_state_nxt = S_OUT;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: config latch, index counters, accumulator and registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m     <= '0;
            r_n     <= '0;
            r_p     <= '0;
            r_sgn   <= 1'b0;
            r_trans <= 1'b0;
            r_r     <= '0;
            r_c     <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            c_out   <= '0;
            c_row   <= '0;
            c_col   <= '0;
            c_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            busy <= (w_state_nxt != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (start && w_legal) begin
                        r_m     <= m_cfg;
                        r_n     <= n_cfg;
                        r_p     <= p_cfg;
                        r_sgn   <= signed_md;
                        r_trans <= trans_b;
                        r_r     <= '0;
                        r_c     <= '0;
                        r_k     <= '0;
                        r_acc   <= '0;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_sum;
                    r_k   <= r_k + 1'b1;
                    if (w_k_last) begin
                        c_out   <= f_result(w_acc_sum, r_sgn);
                        c_row   <= r_r;
                        c_col   <= r_c;
                        c_valid <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (w_hs) begin
                        c_valid <= 1'b0;
                        r_acc   <= '0;
                        r_k     <= '0;
                        if (w_last_elem) begin
                            done <= 1'b1;
                        end else if (w_c_last) begin
                            r_c <= '0;
                            r_r <= r_r + 1'b1;
                        end else begin
                            r_c <= r_c + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    c_valid <= 1'b0;
                end
                default: begin
                    c_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_matrix_mult_engine.sv
// Bench for config_matrix_mult_engine: saturating and truncating instances share stimulus and are
// scored against an integer-arithmetic matrix product model.
module tb_config_matrix_mult_engine;

    logic        clk = 1'b0;
    logic        rst, start, signed_md, trans_b, a_wen, b_wen, c_ready;
    logic [2:0]  m_cfg, n_cfg, p_cfg;
    logic [7:0]  a_in, b_in;
    logic [3:0]  a_addr, b_addr;
    logic [15:0] c_out_s, c_out_t;
    logic [1:0]  c_row_s, c_row_t, c_col_s, c_col_t;
    logic        c_valid_s, c_valid_t, busy_s, busy_t, done_s, done_t, err_s, err_t;

    always #5 clk = ~clk;

    config_matrix_mult_engine #(.SATURATE(1)) u_dut_sat (
        .clk(clk), .rst(rst), .start(start), .m_cfg(m_cfg), .n_cfg(n_cfg), .p_cfg(p_cfg),
        .signed_md(signed_md), .trans_b(trans_b), .a_in(a_in), .a_addr(a_addr), .a_wen(a_wen),
        .b_in(b_in), .b_addr(b_addr), .b_wen(b_wen), .c_out(c_out_s), .c_row(c_row_s),
        .c_col(c_col_s), .c_valid(c_valid_s), .c_ready(c_ready), .busy(busy_s), .done(done_s),
        .err(err_s));

    config_matrix_mult_engine #(.SATURATE(0)) u_dut_trn (
        .clk(clk), .rst(rst), .start(start), .m_cfg(m_cfg), .n_cfg(n_cfg), .p_cfg(p_cfg),
        .signed_md(signed_md), .trans_b(trans_b), .a_in(a_in), .a_addr(a_addr), .a_wen(a_wen),
        .b_in(b_in), .b_addr(b_addr), .b_wen(b_wen), .c_out(c_out_t), .c_row(c_row_t),
        .c_col(c_col_t), .c_valid(c_valid_t), .c_ready(c_ready), .busy(busy_t), .done(done_t),
        .err(err_t));

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ma [4][4];
    logic [7:0] mb [4][4];
    int  cur_m, cur_n, cur_p;
    bit  cur_sgn, cur_trans;

    logic [15:0] q_s[$];
    logic [15:0] q_t[$];
    int          q_r[$];
    int          q_c[$];
    int          q_rt[$];
    int          q_ct[$];

    int exp1 [8] = '{3, 9, 2, 1, 6, 21, 2, 7};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_elem(input int r, input int c, input bit sat);
        longint s = 0;
        longint av, bv;
        for (int k = 0; k < cur_n; k++) begin
            av = longint'(ma[r][k]);
            bv = longint'(mb[k][c]);
            if (cur_sgn && av > 127) av = av - 256;
            if (cur_sgn && bv > 127) bv = bv - 256;
            s = s + av * bv;
        end
        if (sat) begin
            if (cur_sgn) begin
                if (s > 32767) s = 32767;
                else if (s < -32768) s = -32768;
            end else if (s > 65535) begin
                s = 65535;
            end
        end
        return s[15:0];
    endfunction

    task automatic load_banks();
        for (int r = 0; r < cur_m; r++) begin
            for (int k = 0; k < cur_n; k++) begin
                a_addr = 4'(r * cur_n + k);
                a_in   = ma[r][k];
                a_wen  = 1'b1;
                tick();
            end
        end
        a_wen = 1'b0;
        for (int k = 0; k < cur_n; k++) begin
            for (int c = 0; c < cur_p; c++) begin
                b_addr = cur_trans ? 4'(c * cur_n + k) : 4'(k * cur_p + c);
                b_in   = mb[k][c];
                b_wen  = 1'b1;
                tick();
            end
        end
        b_wen = 1'b0;
    endtask

    task automatic run_mat(input int stall, input bit poke);
        int cyc, wait_cnt, last_hs, budget, total;
        bit done_seen, poked;
        logic [15:0] snap_o;
        logic [1:0]  snap_r, snap_c;
        q_s.delete(); q_t.delete(); q_r.delete(); q_c.delete(); q_rt.delete(); q_ct.delete();
        m_cfg = 3'(cur_m); n_cfg = 3'(cur_n); p_cfg = 3'(cur_p);
        signed_md = cur_sgn; trans_b = cur_trans;
        c_ready = (stall == 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("busy_after_start", {busy_s, busy_t}, 2'b11);
        cyc = 0; wait_cnt = 0; last_hs = -1; done_seen = 1'b0; poked = 1'b0;
        snap_o = '0; snap_r = '0; snap_c = '0;
        total  = cur_m * cur_p;
        budget = total * (cur_n + stall + 3) + 40;
        while (!done_seen && cyc < budget) begin
            tick();
            cyc++;
            start = 1'b0;
            a_wen = 1'b0;
            if (stall > 0) c_ready = 1'b0;
            if (done_s) begin
                done_seen = 1'b1;
                check_val("done_timing", cyc, last_hs);
                check_val("done_trunc", done_t, 1'b1);
            end else if (c_valid_s) begin
                if (wait_cnt < stall) begin
                    if (wait_cnt == 0) begin
                        snap_o = c_out_s; snap_r = c_row_s; snap_c = c_col_s;
                    end else begin
                        check_val("hold_out", c_out_s, snap_o);
                        check_val("hold_rc", {c_row_s, c_col_s}, {snap_r, snap_c});
                    end
                    if (poke && !poked) begin
                        // start, config and bank writes while busy must all be ignored
                        start = 1'b1; n_cfg = 3'd1; signed_md = ~signed_md;
                        a_wen = 1'b1; a_addr = 4'd0; a_in = 8'h7F;
                        poked = 1'b1;
                    end
                    wait_cnt++;
                end else begin
                    if (stall > 0) begin
                        check_val("hold_out", c_out_s, snap_o);
                        check_val("hold_rc", {c_row_s, c_col_s}, {snap_r, snap_c});
                        c_ready = 1'b1;
                    end
                    check_val("trunc_valid", c_valid_t, 1'b1);
                    q_s.push_back(c_out_s); q_t.push_back(c_out_t);
                    q_r.push_back(int'(c_row_s)); q_c.push_back(int'(c_col_s));
                    q_rt.push_back(int'(c_row_t)); q_ct.push_back(int'(c_col_t));
                    last_hs  = cyc + 1;
                    wait_cnt = 0;
                end
            end
        end
        if (!done_seen) check_val("timeout_done", 1'b0, 1'b1);
        tick();
        check_val("done_one_cycle", done_s, 1'b0);
        check_val("busy_idle", {busy_s, busy_t}, 2'b00);
        check_val("count", q_s.size(), total);
        for (int i = 0; i < q_s.size() && i < total; i++) begin
            check_val("row", q_r[i], i / cur_p);
            check_val("col", q_c[i], i % cur_p);
            check_val("row_col_trunc", {q_rt[i], q_ct[i]}, {i / cur_p, i % cur_p});
            check_val("c_sat", q_s[i], model_elem(i / cur_p, i % cur_p, 1'b1));
            check_val("c_trunc", q_t[i], model_elem(i / cur_p, i % cur_p, 1'b0));
        end
    endtask

    task automatic set_t1();
        logic [7:0] a_t [2][3] = '{'{8'd1, 8'd2, 8'd3}, '{8'd4, 8'd5, 8'd6}};
        logic [7:0] b_t [3][4] = '{'{8'd1, 8'd0, 8'hFF, 8'd2},
                                   '{8'hFE, 8'd3, 8'd0, 8'd1},
                                   '{8'd2, 8'd1, 8'd1, 8'hFF}};
        cur_m = 2; cur_n = 3; cur_p = 4; cur_sgn = 1'b1; cur_trans = 1'b0;
        for (int r = 0; r < 2; r++) for (int k = 0; k < 3; k++) ma[r][k] = a_t[r][k];
        for (int k = 0; k < 3; k++) for (int c = 0; c < 4; c++) mb[k][c] = b_t[k][c];
    endtask

    task automatic check_t1_stream(input string tag);
        check_val(tag, q_s.size(), 8);
        for (int i = 0; i < q_s.size() && i < 8; i++) check_val(tag, q_s[i], 16'(exp1[i]));
    endtask

    initial begin
        int any_done;
        rst = 1'b1; start = 1'b0; signed_md = 1'b0; trans_b = 1'b0;
        a_wen = 1'b0; b_wen = 1'b0; c_ready = 1'b1;
        m_cfg = 3'd0; n_cfg = 3'd0; p_cfg = 3'd0;
        a_in = 8'd0; b_in = 8'd0; a_addr = 4'd0; b_addr = 4'd0;
        tick(); tick();
        check_val("rst_c_out", c_out_s, 16'd0);
        check_val("rst_rc", {c_row_s, c_col_s}, 4'd0);
        check_val("rst_valid", c_valid_s, 1'b0);
        check_val("rst_busy", busy_s, 1'b0);
        check_val("rst_done_err", {done_s, err_s}, 2'b00);
        rst = 1'b0;
        tick();

        set_t1(); load_banks(); run_mat(0, 1'b0); check_t1_stream("t1_stream");

        cur_trans = 1'b1; load_banks(); run_mat(0, 1'b0); check_t1_stream("t2_trans_stream");

        cur_m = 1; cur_n = 4; cur_p = 1; cur_sgn = 1'b1; cur_trans = 1'b0;
        for (int k = 0; k < 4; k++) begin ma[0][k] = 8'h80; mb[k][0] = 8'h80; end
        load_banks(); run_mat(0, 1'b0);
        if (q_s.size() > 0) begin
            check_val("t3_sat", q_s[0], 16'd32767);
            check_val("t3_trunc", q_t[0], 16'd0);
        end else check_val("t3_count", 0, 1);

        cur_m = 1; cur_n = 1; cur_p = 1; cur_sgn = 1'b0;
        ma[0][0] = 8'hFF; mb[0][0] = 8'hFF;
        load_banks(); run_mat(0, 1'b0);
        if (q_s.size() > 0) check_val("t4_unsigned", {q_s[0], q_t[0]}, {16'hFE01, 16'hFE01});
        else check_val("t4_count", 0, 1);
        cur_sgn = 1'b1; run_mat(0, 1'b0);
        if (q_s.size() > 0) check_val("t4_signed", {q_s[0], q_t[0]}, {16'd1, 16'd1});
        else check_val("t4s_count", 0, 1);

        set_t1(); load_banks(); run_mat(5, 1'b1); check_t1_stream("t5_backpressure");

        m_cfg = 3'd2; n_cfg = 3'd0; p_cfg = 3'd4; start = 1'b1;
        tick(); start = 1'b0;
        check_val("t6_err_n0", {err_s, err_t}, 2'b11);
        check_val("t6_busy_valid", {busy_s, c_valid_s}, 2'b00);
        tick();
        check_val("t6_err_pulse", err_s, 1'b0);
        m_cfg = 3'd5; n_cfg = 3'd3; start = 1'b1;
        tick(); start = 1'b0;
        check_val("t6_err_m5", err_s, 1'b1);
        check_val("t6_busy_m5", busy_s, 1'b0);

        m_cfg = 3'd2; n_cfg = 3'd3; p_cfg = 3'd4; signed_md = 1'b1; trans_b = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        check_val("t6_busy_mac", busy_s, 1'b1);
        rst = 1'b1;
        tick(); rst = 1'b0;
        check_val("t6_abort", {c_valid_s, busy_s}, 2'b00);
        any_done = 0;
        for (int i = 0; i < 6; i++) begin tick(); any_done = any_done | int'(done_s); end
        check_val("t6_no_done", any_done, 0);
        run_mat(0, 1'b0); check_t1_stream("t6_restart_stream");

        for (int it = 0; it < 8; it++) begin
            cur_m = $urandom_range(1, 4); cur_n = $urandom_range(1, 4); cur_p = $urandom_range(1, 4);
            cur_sgn = 1'($urandom); cur_trans = 1'($urandom);
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (it % 2 == 0) begin
                        ma[r][c] = ($urandom_range(0, 1) == 0) ? 8'h80 : 8'hFF;
                        mb[r][c] = ($urandom_range(0, 1) == 0) ? 8'h80 : 8'h7F;
                    end else begin
                        ma[r][c] = 8'($urandom);
                        mb[r][c] = 8'($urandom);
                    end
                end
            end
            load_banks();
            run_mat($urandom_range(0, 2), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
